ad9280_sample: RTL and testbench

- Front-end capture stage for the AD9280 8-bit ADC. It sits directly upstream of the UART reporting block and drives that block's ad9280_data input.
- Generates the ADC sample clock from the system clock and captures raw samples.
- Averages a power-of-two number of samples and presents a stable averaged byte with a one-cycle valid strobe.
- Tracks running peak max/min for diagnostics.

---
 rtl/ad9280_sample_if.sv | 19 +
 rtl/ad9280_sample.sv | 77 +++++++
 tb/tb_ad9280_sample.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ad9280_sample_if.sv
// ad9280_sample_if: ADC pin, control and result signals of the AD9280 capture stage.
interface ad9280_sample_if;
   logic       adc_en;
   logic       ad9280_clk;
   logic [7:0] ad9280_din;
   logic [7:0] ad9280_data;
   logic       data_valid;
   logic       peak_clr;
   logic [7:0] peak_max;
   logic [7:0] peak_min;
   modport master (
      output adc_en, ad9280_din, peak_clr,
      input  ad9280_clk, ad9280_data, data_valid, peak_max, peak_min
   );
   modport slave (
      input  adc_en, ad9280_din, peak_clr,
      output ad9280_clk, ad9280_data, data_valid, peak_max, peak_min
   );
endinterface

// File: rtl/ad9280_sample.sv
// ad9280_sample: AD9280 sample clock generation, capture, power-of-two averaging
// and running peak tracking.
module ad9280_sample #(
   parameter int CLK_FRE  = 50,
   parameter int ADC_DIV  = 2,
   parameter int AVG_LOG2 = 2
) (
   input logic            clk,
   input logic            rst,
   ad9280_sample_if.slave bus
);
   localparam int DW = ADC_DIV > 1 ? $clog2(ADC_DIV) : 1;
   localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
   localparam int AW = 8 + AVG_LOG2;
   typedef enum logic {IDLE, RUN} state_t;
   state_t        r_state, w_nxt;
   logic [DW-1:0] r_div_cnt;
   logic [SW-1:0] r_smp_cnt;
   logic [AW-1:0] r_acc, w_sum;
   logic [7:0]    r_cap, r_data, r_pmax, r_pmin, w_avg;
   logic          r_adc_clk, r_cap_vld, r_valid, w_run, w_div_end, w_strobe, w_last;

   if (CLK_FRE < 1 || ADC_DIV < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_bad_param
      $error("ad9280_sample: illegal parameter value");
   end

   always_comb begin
      w_nxt     = bus.adc_en ? RUN : IDLE;
      w_run     = r_state == RUN && bus.adc_en;
      w_div_end = r_div_cnt == DW'(ADC_DIV - 1);
      // sample in the last high cycle, just before the ADC clock falls
      w_strobe  = w_run && w_div_end && r_adc_clk;
      w_last    = r_smp_cnt == SW'((1 << AVG_LOG2) - 1);
      w_sum     = r_acc + AW'(r_cap);
      w_avg     = 8'(w_sum >> AVG_LOG2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_div_cnt <= '0;
         r_adc_clk <= 1'b0;
         r_cap     <= '0;
         r_cap_vld <= 1'b0;
         r_acc     <= '0;
         r_smp_cnt <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_pmax    <= 8'h00;
         r_pmin    <= 8'hFF;
      end else begin
         r_state   <= w_nxt;
         r_div_cnt <= w_run && !w_div_end ? r_div_cnt + DW'(1) : '0;
         r_adc_clk <= w_run && (r_adc_clk ^ w_div_end);
         r_cap_vld <= w_strobe;
         if (w_strobe) r_cap <= bus.ad9280_din;
         // a completing sample still publishes even when adc_en drops in the same cycle
         r_valid   <= r_cap_vld && w_last;
         if (r_cap_vld && w_last) r_data <= w_avg;
         r_acc     <= !w_run || (r_cap_vld && w_last) ? '0 : r_cap_vld ? w_sum : r_acc;
         r_smp_cnt <= !w_run || (r_cap_vld && w_last) ? '0 : r_cap_vld ? r_smp_cnt + SW'(1) : r_smp_cnt;
         if (bus.peak_clr) begin
            r_pmax <= r_cap_vld ? r_cap : 8'h00;
            r_pmin <= r_cap_vld ? r_cap : 8'hFF;
         end else if (r_cap_vld) begin
            if (r_cap > r_pmax) r_pmax <= r_cap;
            if (r_cap < r_pmin) r_pmin <= r_cap;
         end
      end
   end

   assign bus.ad9280_clk  = r_adc_clk;
   assign bus.ad9280_data = r_data;
   assign bus.data_valid  = r_valid;
   assign bus.peak_max    = r_pmax;
   assign bus.peak_min    = r_pmin;
endmodule

// File: tb/tb_ad9280_sample.sv
// tb_ad9280_sample: scoreboard bench for ad9280_sample; averages are queued when
// samples are driven and popped when data_valid fires.
module tb_ad9280_sample;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] sb_e;

   ad9280_sample_if a();
   ad9280_sample_if b();

   ad9280_sample #(.CLK_FRE(50), .ADC_DIV(2), .AVG_LOG2(2)) dut  (.clk(clk), .rst(rst), .bus(a.slave));
   ad9280_sample #(.CLK_FRE(50), .ADC_DIV(2), .AVG_LOG2(0)) dut0 (.clk(clk), .rst(rst), .bus(b.slave));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (a.data_valid === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: data_valid=1 data=%h, required data_valid=0", a.ad9280_data);
         end else begin
            sb_e = exp_q.pop_front();
            if (a.ad9280_data !== sb_e) begin
               n_bad++;
               $display("FAIL sb_data: got %h, required %h", a.ad9280_data, sb_e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // returns in the cycle right after the ADC clock falls, i.e. with the sample's cap_vld high
   task automatic send(input logic [7:0] v);
      bit hi = 1'b0;
      a.ad9280_din = v;
      for (int i = 0; i < 24; i++) begin
         step();
         if (a.ad9280_clk === 1'b1) hi = 1'b1;
         else if (hi) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: no ADC clock fall for sample %h, required one within 24 cycles", v);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (a.ad9280_clk !== 1'b0) begin n_bad++; $display("FAIL rst_clk: got %b, required 0", a.ad9280_clk); end
      n_cmp++; if (a.ad9280_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h, required 00", a.ad9280_data); end
      n_cmp++; if (a.data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", a.data_valid); end
      n_cmp++; if (a.peak_max !== 8'h00) begin n_bad++; $display("FAIL rst_pmax: got %h, required 00", a.peak_max); end
      n_cmp++; if (a.peak_min !== 8'hFF) begin n_bad++; $display("FAIL rst_pmin: got %h, required ff", a.peak_min); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();
   endtask

   task automatic test_steady();
      int   rise[$];
      int   vld[$];
      logic prev = 1'b0;
      a.ad9280_din = 8'h80;
      a.adc_en = 1'b1;
      repeat (3) exp_q.push_back(8'h80);
      for (int i = 1; i <= 50; i++) begin
         step();
         if (a.ad9280_clk === 1'b1 && !prev) rise.push_back(i);
         if (a.data_valid === 1'b1) vld.push_back(i);
         prev = a.ad9280_clk;
      end
      a.adc_en = 1'b0;
      n_cmp++; if (rise.size() == 0 || rise[0] != 3) begin n_bad++; $display("FAIL steady_first_rise: got %0d rises first=%0d, required first at 3", rise.size(), rise.size() ? rise[0] : -1); end
      for (int i = 1; i < rise.size(); i++) begin
         n_cmp++; if (rise[i] - rise[i-1] != 4) begin n_bad++; $display("FAIL steady_clk_period: got %0d, required 4", rise[i] - rise[i-1]); end
      end
      n_cmp++; if (vld.size() != 3 || vld[0] != 18) begin n_bad++; $display("FAIL steady_valid: got %0d strobes first=%0d, required 3 first at 18", vld.size(), vld.size() ? vld[0] : -1); end
      for (int i = 1; i < vld.size(); i++) begin
         n_cmp++; if (vld[i] - vld[i-1] != 16) begin n_bad++; $display("FAIL steady_cadence: got %0d, required 16", vld[i] - vld[i-1]); end
      end
      n_cmp++; if (a.peak_max !== 8'h80) begin n_bad++; $display("FAIL steady_pmax: got %h, required 80", a.peak_max); end
      n_cmp++; if (a.peak_min !== 8'h80) begin n_bad++; $display("FAIL steady_pmin: got %h, required 80", a.peak_min); end
      repeat (2) step();
   endtask

   task automatic test_avg();
      a.peak_clr = 1'b1;
      step();
      a.peak_clr = 1'b0;
      n_cmp++; if (a.peak_max !== 8'h00) begin n_bad++; $display("FAIL clr_pmax: got %h, required 00", a.peak_max); end
      n_cmp++; if (a.peak_min !== 8'hFF) begin n_bad++; $display("FAIL clr_pmin: got %h, required ff", a.peak_min); end
      a.adc_en = 1'b1;
      exp_q.push_back(8'd11);
      send(8'd10); send(8'd11); send(8'd12); send(8'd13);
      step();
      n_cmp++; if (a.data_valid !== 1'b1 || a.ad9280_data !== 8'd11) begin n_bad++; $display("FAIL avg_latency: got valid=%b data=%h, required valid=1 data=0b", a.data_valid, a.ad9280_data); end
      step();
      n_cmp++; if (a.data_valid !== 1'b0) begin n_bad++; $display("FAIL avg_pulse: got %b, required 0", a.data_valid); end
      n_cmp++; if (a.peak_max !== 8'd13) begin n_bad++; $display("FAIL avg_pmax: got %h, required 0d", a.peak_max); end
      n_cmp++; if (a.peak_min !== 8'd10) begin n_bad++; $display("FAIL avg_pmin: got %h, required 0a", a.peak_min); end
      a.adc_en = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_max();
      a.adc_en = 1'b1;
      exp_q.push_back(8'hFF);
      repeat (4) send(8'hFF);
      step();
      n_cmp++; if (a.data_valid !== 1'b1 || a.ad9280_data !== 8'hFF) begin n_bad++; $display("FAIL max_nowrap: got valid=%b data=%h, required valid=1 data=ff", a.data_valid, a.ad9280_data); end
      a.adc_en = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_passthru();
      int cnt = 0;
      b.ad9280_din = 8'h37;
      b.adc_en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (b.data_valid === 1'b1) begin
            cnt++;
            n_cmp++; if (b.ad9280_data !== 8'h37) begin n_bad++; $display("FAIL pass_data: got %h, required 37", b.ad9280_data); end
         end
      end
      b.adc_en = 1'b0;
      n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL pass_count: got %0d, required 4", cnt); end
   endtask

   task automatic test_peak_clr();
      a.adc_en = 1'b1;
      send(8'h40);
      a.peak_clr = 1'b1;
      step();
      a.peak_clr = 1'b0;
      n_cmp++; if (a.peak_max !== 8'h40 || a.peak_min !== 8'h40) begin n_bad++; $display("FAIL clrload: got max=%h min=%h, required max=40 min=40", a.peak_max, a.peak_min); end
      send(8'h20);
      step();
      n_cmp++; if (a.peak_max !== 8'h40) begin n_bad++; $display("FAIL clr_then_pmax: got %h, required 40", a.peak_max); end
      n_cmp++; if (a.peak_min !== 8'h20) begin n_bad++; $display("FAIL clr_then_pmin: got %h, required 20", a.peak_min); end
      a.adc_en = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_abort();
      a.adc_en = 1'b1;
      send(8'h90); send(8'h90);
      a.adc_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if (a.ad9280_clk !== 1'b0) begin n_bad++; $display("FAIL idle_clk: got %b, required 0", a.ad9280_clk); end
      end
      a.adc_en = 1'b1;
      exp_q.push_back(8'h10);
      repeat (4) send(8'h10);
      step();
      n_cmp++; if (a.data_valid !== 1'b1 || a.ad9280_data !== 8'h10) begin n_bad++; $display("FAIL abort_regroup: got valid=%b data=%h, required valid=1 data=10", a.data_valid, a.ad9280_data); end
      a.adc_en = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_coincident();
      a.adc_en = 1'b1;
      exp_q.push_back(8'h21);
      repeat (3) send(8'h20);
      send(8'h24);
      a.adc_en = 1'b0;
      step();
      n_cmp++; if (a.data_valid !== 1'b1 || a.ad9280_data !== 8'h21) begin n_bad++; $display("FAIL coinc_update: got valid=%b data=%h, required valid=1 data=21", a.data_valid, a.ad9280_data); end
      repeat (3) step();
      n_cmp++; if (a.ad9280_clk !== 1'b0) begin n_bad++; $display("FAIL coinc_idle_clk: got %b, required 0", a.ad9280_clk); end
   endtask

   task automatic test_rst_mid();
      a.adc_en = 1'b1;
      send(8'h55); send(8'h55);
      repeat (2) step();
      n_cmp++; if (a.ad9280_clk !== 1'b1) begin n_bad++; $display("FAIL mid_clk_high: got %b, required 1", a.ad9280_clk); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (a.ad9280_clk !== 1'b0) begin n_bad++; $display("FAIL mid_rst_clk: got %b, required 0", a.ad9280_clk); end
      n_cmp++; if (a.ad9280_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %h, required 00", a.ad9280_data); end
      n_cmp++; if (a.data_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b, required 0", a.data_valid); end
      n_cmp++; if (a.peak_min !== 8'hFF) begin n_bad++; $display("FAIL mid_rst_pmin: got %h, required ff", a.peak_min); end
      n_cmp++; if (a.peak_max !== 8'h00) begin n_bad++; $display("FAIL mid_rst_pmax: got %h, required 00", a.peak_max); end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++; if (a.data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release_valid: got %b, required 0", a.data_valid); end
      end
      a.adc_en = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      a.adc_en = 1'b0; a.ad9280_din = 8'h00; a.peak_clr = 1'b0;
      b.adc_en = 1'b0; b.ad9280_din = 8'h00; b.peak_clr = 1'b0;
      test_reset();
      test_steady();
      test_avg();
      test_max();
      test_passthru();
      test_peak_clr();
      test_abort();
      test_coincident();
      test_rst_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
